// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: iteration sequencer and angle accumulator for the bit-serial CORDIC rotator.
// Optional CORDIC_EARLY_EXIT_EN: finish as soon as the residual angle reaches exactly zero.
module cordic_iter_ctrl #(
    parameter int N_ITER = 16,
    parameter int ZW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [ZW-1:0] z0,
    input  logic          xdone,
    input  logic          ydone,
    output logic [4:0]    i,
    output logic          start,
    output logic          op,
    output logic [3:0]    selx,
    output logic [3:0]    sely,
    output logic [ZW-1:0] zreg,
    output logic          busy,
    output logic          done
);
    typedef enum logic [2:0] {IDLE, LOAD, ITER, UPDATE, DONE} state_t;
    state_t state, state_n;
    logic [4:0] i_n, bitcnt, bitcnt_n;
    logic [ZW-1:0] zreg_n, zupd, atan;
    logic [3:0] k, sel;
    logic last;

    function automatic logic [15:0] atan_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'h3244;
            4'd1:    return 16'h1DAC;
            4'd2:    return 16'h0FAE;
            4'd3:    return 16'h07F5;
            4'd4:    return 16'h03FF;
            4'd15:   return 16'h0000;
            default: return 16'h4000 >> idx;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            i      <= '0;
            zreg   <= '0;
            bitcnt <= '0;
        end else begin
            state  <= state_n;
            i      <= i_n;
            zreg   <= zreg_n;
            bitcnt <= bitcnt_n;
        end
    end

    always_comb begin
        k = 4'(i - 5'd1);
        atan = ZW'(atan_rom(k));
        zupd = zreg[ZW-1] ? zreg + atan : zreg - atan;
        // Partner register shifts right each cycle, so past bit 15 the tap rides the sign bit.
        sel = (6'(bitcnt) + 6'(k) <= 6'd15) ? k : 4'd15 - bitcnt[3:0];
`ifdef CORDIC_EARLY_EXIT_EN
        last = (i == 5'(N_ITER)) || (zupd == '0);
`else
        last = (i == 5'(N_ITER));
`endif
        start = (state == ITER);
        op = start & zreg[ZW-1];
        selx = (start && !bitcnt[4]) ? sel : 4'd0;
        sely = selx;
        busy = (state == LOAD) || (state == ITER) || (state == UPDATE);
        done = (state == DONE);
        state_n = state;
        i_n = i;
        zreg_n = zreg;
        bitcnt_n = bitcnt;
        case (state)
            IDLE: begin
                i_n = '0;
                bitcnt_n = '0;
                if (go) begin
                    state_n = LOAD;
                    zreg_n = z0;
                end
            end
            LOAD: begin
                state_n = ITER;
                i_n = 5'd1;
            end
            ITER: begin
                bitcnt_n = bitcnt[4] ? bitcnt : bitcnt + 5'd1;
                state_n = (xdone && ydone) ? UPDATE : ITER;
            end
            UPDATE: begin
                bitcnt_n = '0;
                zreg_n = zupd;
                state_n = last ? DONE : ITER;
                i_n = last ? i : i + 5'd1;
            end
            default: begin
                state_n = IDLE;
                i_n = '0;
            end
        endcase
    end
endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
Sequencer for the bit-serial CORDIC rotation datapath.
- Drives the x and y bit-serial stages with the iteration index `i`, the cross-term bit selects `selx`/`sely`, the `start` strobe and the direction `op`.
- Owns the parallel angle accumulator `zreg` and its arctangent ROM.
- Sits directly upstream of the x/y stages and consumes their `xdone`/`ydone`.

Parameters:
- N_ITER, 16, number of rotation iterations (legal 1..16); iteration `i` uses shift k = i−1.
- ZW, 16, angle width; signed, 2^14 = 1 rad.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- go  input  1  start a rotation; sampled only in IDLE.
- z0  input  ZW  target angle, captured when `go` is accepted.
- xdone  input  1  x stage finished 16 shifts.
- ydone  input  1  y stage finished 16 shifts.
- i  output  5  iteration index; 0 = load x0/y0 into the x/y stages.
- start  output  1  shift enable to the x/y stages.
- op  output  1  direction; 1 = z negative, the y stage subtracts and the x stage adds.
- selx  output  4  bit of y register used as the x-stage cross term.
- sely  output  4  bit of x register used as the y-stage cross term.
- zreg  output  ZW  residual angle.
- busy  output  1  high from LOAD until DONE.
- done  output  1  one-cycle pulse when rotation complete.

Behaviour:
- Reset values: state = IDLE, i=0, start=0, op=0, selx=sely=0, zreg=0, busy=0, done=0, bitcnt=0.
- `rst` has priority in every state; mid-rotation reset returns to IDLE in one edge, no `done`.
- IDLE: i=0, start=0.
  - `go=1` → LOAD, zreg←z0.
- LOAD (1 cycle): i=0 so the x/y stages load and clear their counters; busy=1.
  - → ITER with i←1.
- ITER: start=1, op=zreg[ZW−1] (held constant through the iteration).
  - bitcnt increments each cycle while < 16, then saturates at 16.
  - Cross-term select, with k=i−1 and j=bitcnt: sel = k when j+k ≤ 15, else 15−j.
    - This taps original bit j+k, or the sign bit, of the partner register, which shifts right by one per cycle.
  - selx = sely = sel while j < 16; 0 once saturated.
  - When xdone & ydone → UPDATE.
  - Only one of xdone/ydone high: keep waiting; no timeout.
- UPDATE (1 cycle): start=0, which clears the x/y counters and done flags; bitcnt←0.
  - zreg ← zreg − atan(k) if op=0, else zreg + atan(k); ZW-bit wrap arithmetic.
  - i = N_ITER → DONE; else i←i+1 → ITER.
- DONE (1 cycle): done=1, busy=0, start=0, i held. → IDLE.
  - `go` is ignored while busy or in DONE.
- atan ROM, indexed by k:
  - k=0..5: 0x3244, 0x1DAC, 0x0FAE, 0x07F5, 0x03FF, 0x0200.
  - k=6..14: 2^(14−k).
  - k=15: 0.
- Latency per iteration: 16 shift edges + 1 edge for the x/y stages to assert done + 1 edge to sample done + UPDATE = 19 cycles.
- `done` pulses exactly 19·N_ITER + 2 cycles after the edge that samples `go`.

Optional Feature:
- CORDIC_EARLY_EXIT_EN defined: if zreg is exactly 0 after an UPDATE, go straight to DONE, skipping remaining iterations; `i` keeps the last executed index.
- Undefined: always run N_ITER iterations regardless of zreg.

Test Plan:
- Reset mid-ITER at i=5, bitcnt=7 → next cycle state IDLE, i=0, start=0, busy=0, zreg=0, no `done` pulse.
- z0=0x3244, N_ITER=16, x/y stage models → op=0 at i=1, zreg after UPDATE 1 = 0x0000, 16 iterations run, done at cycle 306.
- i=3 (k=2): sel sequence over bitcnt 0..15 → 2 ×14 cycles, then 1, 0; bitcnt=16 → 0.
- z0=0xCDBC (−0x3244) → op=1 at i=1, zreg=0x0000 after the first UPDATE.
- xdone=1 with ydone held 0 for 10 extra cycles → controller stays in ITER, start=1, zreg unchanged; advances one edge after ydone rises.
- With CORDIC_EARLY_EXIT_EN, z0=0x3244 → done asserted after iteration 1 (cycle 21), i=1; without the macro → cycle 306.
